// File: rtl/csr_rmw_sequencer_if.sv
// Signal bundle between issue, the CSR read-modify-write sequencer and the CSR data store.
// The master modport is the sequencer view; slave is the issue/store side.
interface csr_rmw_sequencer_if #(
    parameter int NUM_WARPS     = 4,
    parameter int CSR_ADDR_BITS = 12,
    parameter int CSR_WIDTH     = 12
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [NW_BITS-1:0]       req_wid;
    logic [CSR_ADDR_BITS-1:0] req_addr;
    logic [1:0]               req_op;
    logic                     req_use_imm;
    logic [4:0]               req_imm;
    logic [4:0]               req_rs1_idx;
    logic [31:0]              req_rs1_data;
    logic [4:0]               req_rd;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [NW_BITS-1:0]       rsp_wid;
    logic [4:0]               rsp_rd;
    logic                     rsp_wb;
    logic [31:0]              rsp_data;
    logic                     rsp_illegal;

    logic                     csr_read_enable;
    logic [CSR_ADDR_BITS-1:0] csr_read_addr;
    logic [NW_BITS-1:0]       csr_read_wid;
    logic [31:0]              csr_read_data;
    logic                     csr_write_enable;
    logic [CSR_ADDR_BITS-1:0] csr_write_addr;
    logic [NW_BITS-1:0]       csr_write_wid;
    logic [CSR_WIDTH-1:0]     csr_write_data;

    modport master (
        input  req_valid, req_wid, req_addr, req_op, req_use_imm, req_imm, req_rs1_idx,
               req_rs1_data, req_rd, rsp_ready, csr_read_data,
        output req_ready, rsp_valid, rsp_wid, rsp_rd, rsp_wb, rsp_data, rsp_illegal,
               csr_read_enable, csr_read_addr, csr_read_wid, csr_write_enable,
               csr_write_addr, csr_write_wid, csr_write_data
    );

    modport slave (
        output req_valid, req_wid, req_addr, req_op, req_use_imm, req_imm, req_rs1_idx,
               req_rs1_data, req_rd, rsp_ready, csr_read_data,
        input  req_ready, rsp_valid, rsp_wid, rsp_rd, rsp_wb, rsp_data, rsp_illegal,
               csr_read_enable, csr_read_addr, csr_read_wid, csr_write_enable,
               csr_write_addr, csr_write_wid, csr_write_data
    );
endinterface

// File: rtl/csr_rmw_sequencer.sv
// Serialises CSR instructions into a read cycle, an optional write cycle and a held response
// carrying the old CSR value for register writeback.
module csr_rmw_sequencer #(
    parameter int NUM_WARPS     = 4,
    parameter int CSR_ADDR_BITS = 12,
    parameter int CSR_WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    csr_rmw_sequencer_if.master  bus,
    output logic                 o_busy
);
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StRsp} state_e;

    state_e                   r_state;
    state_e                   w_state_next;

    logic [NW_BITS-1:0]       r_wid;
    logic [CSR_ADDR_BITS-1:0] r_addr;
    logic [1:0]               r_op;
    logic                     r_use_imm;
    logic [4:0]               r_imm;
    logic [4:0]               r_rs1_idx;
    logic [31:0]              r_rs1_data;
    logic [4:0]               r_rd;
    logic [31:0]              r_old;
    logic [CSR_WIDTH-1:0]     r_new;
    logic                     r_illegal;

    logic                     w_accept;
    logic [31:0]              w_src;
    logic [31:0]              w_new;
    logic                     w_do_write;
    logic                     w_ro;
    logic                     w_unused_new;

    assign w_accept     = (r_state == StIdle) && bus.req_valid;
    // Only the low CSR_WIDTH bits of the computed value reach the store.
    assign w_unused_new = ^w_new;

    always_comb begin
        w_src = r_use_imm ? {27'b0, r_imm} : r_rs1_data;
        case (r_op)
            2'b01:   w_new = w_src;
            2'b10:   w_new = bus.csr_read_data | w_src;
            2'b11:   w_new = bus.csr_read_data & ~w_src;
            default: w_new = bus.csr_read_data;
        endcase
        // Set/clear with a zero source (x0 or uimm 0) is a pure read.
        w_do_write = (r_op == 2'b01) ||
                     (r_op[1] && (r_use_imm ? (r_imm != 5'd0) : (r_rs1_idx != 5'd0)));
        w_ro       = (r_addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.req_valid) w_state_next = StRead;
            StRead:  w_state_next = (w_do_write && !w_ro) ? StWrite : StRsp;
            StWrite: w_state_next = StRsp;
            StRsp:   if (bus.rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        bus.req_ready        = (r_state == StIdle);
        bus.rsp_valid        = 1'b0;
        bus.rsp_wid          = '0;
        bus.rsp_rd           = '0;
        bus.rsp_wb           = 1'b0;
        bus.rsp_data         = '0;
        bus.rsp_illegal      = 1'b0;
        bus.csr_read_enable  = 1'b0;
        bus.csr_read_addr    = '0;
        bus.csr_read_wid     = '0;
        bus.csr_write_enable = 1'b0;
        bus.csr_write_addr   = '0;
        bus.csr_write_wid    = '0;
        bus.csr_write_data   = '0;
        o_busy               = (r_state != StIdle);
        unique case (r_state)
            StRead: begin
                bus.csr_read_enable = 1'b1;
                bus.csr_read_addr   = r_addr;
                bus.csr_read_wid    = r_wid;
            end
            StWrite: begin
                bus.csr_write_enable = 1'b1;
                bus.csr_write_addr   = r_addr;
                bus.csr_write_wid    = r_wid;
                bus.csr_write_data   = r_new;
            end
            StRsp: begin
                bus.rsp_valid   = 1'b1;
                bus.rsp_wid     = r_wid;
                bus.rsp_rd      = r_rd;
                bus.rsp_wb      = (r_rd != 5'd0);
                bus.rsp_data    = r_old;
                bus.rsp_illegal = r_illegal;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_wid      <= '0;
            r_addr     <= '0;
            r_op       <= '0;
            r_use_imm  <= 1'b0;
            r_imm      <= '0;
            r_rs1_idx  <= '0;
            r_rs1_data <= '0;
            r_rd       <= '0;
            r_old      <= '0;
            r_new      <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_wid      <= bus.req_wid;
                r_addr     <= bus.req_addr;
                r_op       <= bus.req_op;
                r_use_imm  <= bus.req_use_imm;
                r_imm      <= bus.req_imm;
                r_rs1_idx  <= bus.req_rs1_idx;
                r_rs1_data <= bus.req_rs1_data;
                r_rd       <= bus.req_rd;
            end
            if (r_state == StRead) begin
                r_old     <= bus.csr_read_data;
                r_new     <= w_new[CSR_WIDTH-1:0];
                r_illegal <= w_do_write && w_ro;
            end
        end
    end
endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Directed bench for csr_rmw_sequencer: a store stub returns a programmed value and every
// step checks strobes, write data and the held response against hand-computed values.
module tb_csr_rmw_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [31:0] store_val;
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          ovl_cnt = 0;
    int          w0;

    csr_rmw_sequencer_if #(.NUM_WARPS(4), .CSR_ADDR_BITS(12), .CSR_WIDTH(12)) bus ();

    csr_rmw_sequencer #(.NUM_WARPS(4), .CSR_ADDR_BITS(12), .CSR_WIDTH(12)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .o_busy (busy)
    );

    always #5 clk = ~clk;

    assign bus.csr_read_data = bus.csr_read_enable ? store_val : 32'h0BAD_F00D;

    always @(negedge clk) begin
        if (bus.csr_write_enable === 1'b1) wr_cnt = wr_cnt + 1;
        if (bus.csr_write_enable === 1'b1 && bus.csr_read_enable === 1'b1) ovl_cnt = ovl_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request, lets it be accepted, and leaves the DUT in its read cycle.
    task automatic issue(input logic [1:0] wid, input logic [11:0] addr, input logic [1:0] op,
                         input logic use_imm, input logic [4:0] imm, input logic [4:0] rs1_idx,
                         input logic [31:0] rs1_data, input logic [4:0] rd,
                         input logic [31:0] stored);
        bus.req_wid      = wid;
        bus.req_addr     = addr;
        bus.req_op       = op;
        bus.req_use_imm  = use_imm;
        bus.req_imm      = imm;
        bus.req_rs1_idx  = rs1_idx;
        bus.req_rs1_data = rs1_data;
        bus.req_rd       = rd;
        store_val        = stored;
        bus.req_valid    = 1'b1;
        tick();
        bus.req_valid    = 1'b0;
    endtask

    task automatic respond();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_wid      = '0;
        bus.req_addr     = '0;
        bus.req_op       = '0;
        bus.req_use_imm  = 1'b0;
        bus.req_imm      = '0;
        bus.req_rs1_idx  = '0;
        bus.req_rs1_data = '0;
        bus.req_rd       = '0;
        bus.rsp_ready    = 1'b0;
        store_val        = '0;
        repeat (3) tick();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_strobes", {bus.csr_read_enable, bus.csr_write_enable}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_flags", {bus.req_ready, busy, bus.csr_read_enable,
                               bus.csr_write_enable, bus.rsp_valid}, 5'b10000);
        end

        // CSRRW 0x300, wid 2: read T+1, write 0xABC T+2, response T+3
        issue(2'd2, 12'h300, 2'b01, 1'b0, 5'd0, 5'd5, 32'h0000_0ABC, 5'd7, 32'h0000_0123);
        chk("rw_rd_en", bus.csr_read_enable, 1);
        chk("rw_rd_addr", bus.csr_read_addr, 12'h300);
        chk("rw_rd_wid", bus.csr_read_wid, 2);
        chk("rw_rd_nowr", bus.csr_write_enable, 0);
        chk("rw_busy", busy, 1);
        chk("rw_not_ready", bus.req_ready, 0);
        tick();
        chk("rw_wr_en", bus.csr_write_enable, 1);
        chk("rw_wr_data", bus.csr_write_data, 12'hABC);
        chk("rw_wr_addr", bus.csr_write_addr, 12'h300);
        chk("rw_wr_wid", bus.csr_write_wid, 2);
        chk("rw_wr_nord", {bus.csr_read_enable, bus.csr_read_addr}, 0);
        tick();
        chk("rw_rsp_valid", bus.rsp_valid, 1);
        chk("rw_rsp_data", bus.rsp_data, 32'h123);
        chk("rw_rsp_meta", {bus.rsp_wid, bus.rsp_rd, bus.rsp_wb, bus.rsp_illegal},
            {2'd2, 5'd7, 1'b1, 1'b0});
        chk("rw_rsp_nowr", {bus.csr_write_enable, bus.csr_write_addr}, 0);
        respond();
        chk("rw_done", {busy, bus.rsp_valid, bus.req_ready}, 3'b001);

        // CSRRSI uimm 5 on 0x0A0 -> 0x0A5
        issue(2'd1, 12'h300, 2'b10, 1'b1, 5'd5, 5'd0, 32'hFFFF_FFFF, 5'd3, 32'h0000_00A0);
        tick();
        chk("rsi_wr_en", bus.csr_write_enable, 1);
        chk("rsi_wr_data", bus.csr_write_data, 12'h0A5);
        tick();
        chk("rsi_rsp_data", bus.rsp_data, 32'h0A0);
        respond();

        // CSRRC rs1 0x0A0 on 0x0A5 -> 0x005
        issue(2'd1, 12'h300, 2'b11, 1'b0, 5'd0, 5'd4, 32'h0000_00A0, 5'd3, 32'h0000_00A5);
        tick();
        chk("rc_wr_en", bus.csr_write_enable, 1);
        chk("rc_wr_data", bus.csr_write_data, 12'h005);
        tick();
        chk("rc_rsp", {bus.rsp_valid, bus.rsp_data}, {1'b1, 32'h0A5});
        respond();

        // CSRRS x0 on read-only 0xC00: pure read, response at T+2
        w0 = wr_cnt;
        issue(2'd0, 12'hC00, 2'b10, 1'b0, 5'd0, 5'd0, 32'h0000_0FFF, 5'd9, 32'h0000_0777);
        chk("ro_rd_en", bus.csr_read_enable, 1);
        tick();
        chk("ro_rsp_valid", bus.rsp_valid, 1);
        chk("ro_rsp", {bus.rsp_illegal, bus.rsp_data}, {1'b0, 32'h777});
        respond();
        chk("ro_nowrite", wr_cnt, w0);

        // CSRRW on read-only 0xC00: illegal, no write
        issue(2'd3, 12'hC00, 2'b01, 1'b0, 5'd0, 5'd2, 32'h0000_0055, 5'd0, 32'h0000_0888);
        tick();
        chk("ill_rsp_valid", bus.rsp_valid, 1);
        chk("ill_rsp", {bus.rsp_illegal, bus.rsp_wb, bus.rsp_wid, bus.rsp_data},
            {1'b1, 1'b0, 2'd3, 32'h888});
        respond();
        chk("ill_nowrite", wr_cnt, w0);

        // CSRRC on a wide store value; response held with a second request pending
        issue(2'd2, 12'h340, 2'b11, 1'b0, 5'd0, 5'd6, 32'h0000_000F, 5'd0, 32'h8000_0F0F);
        tick();
        chk("hold_wr_data", bus.csr_write_data, 12'hF00);
        tick();
        bus.req_wid   = 2'd1;
        bus.req_addr  = 12'h300;
        bus.req_op    = 2'b00;
        bus.req_rd    = 5'd4;
        bus.req_valid = 1'b1;
        store_val     = 32'h0000_05A5;
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp", {bus.rsp_valid, bus.rsp_wb, bus.rsp_wid, bus.rsp_data},
                {1'b1, 1'b0, 2'd2, 32'h8000_0F0F});
            chk("hold_stall", {bus.req_ready, bus.csr_read_enable, bus.csr_write_enable}, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("hold_release", {bus.req_ready, bus.rsp_valid, bus.csr_read_enable}, 3'b100);
        tick();
        bus.req_valid = 1'b0;
        chk("next_rd", {bus.csr_read_enable, bus.csr_read_addr, bus.csr_read_wid},
            {1'b1, 12'h300, 2'd1});
        tick();
        chk("next_rsp", {bus.rsp_valid, bus.rsp_illegal, bus.rsp_wb, bus.rsp_data},
            {1'b1, 1'b0, 1'b1, 32'h5A5});
        respond();
        chk("next_nowrite", wr_cnt, w0);

        // Reset during the read cycle aborts with no write
        w0 = wr_cnt;
        issue(2'd1, 12'h300, 2'b01, 1'b0, 5'd0, 5'd5, 32'h0000_0111, 5'd2, 32'h0000_0222);
        chk("abort_rd_en", bus.csr_read_enable, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_idle", {busy, bus.rsp_valid, bus.req_ready, bus.csr_write_enable}, 4'b0010);
        repeat (3) tick();
        chk("abort_quiet", {busy, bus.rsp_valid}, 0);
        chk("abort_nowrite", wr_cnt, w0);

        chk("strobe_overlap", ovl_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csr_rmw_sequencer.md
Name: csr_rmw_sequencer

Overview:
- Initiator side of the CSR data-store read/write port pair.
- Accepts decoded CSR instructions (CSRRW/CSRRS/CSRRC and their immediate forms, plus a plain read) from issue.
- Performs the read-modify-write against the CSR data store: a read cycle, then an optional write cycle.
- Returns the old CSR value for register writeback through a valid/ready response channel.
- Sits between the issue stage and the CSR data store; serialises one CSR instruction at a time.

Parameters:
NUM_WARPS, 4, number of warps; NW_BITS = max(1, clog2(NUM_WARPS))
CSR_ADDR_BITS, 12, CSR address width
CSR_WIDTH, 12, width of CSR write data driven to the store (low bits of computed value)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_wid  in  NW_BITS  warp id
req_addr  in  CSR_ADDR_BITS  CSR address
req_op  in  2  00=read only, 01=RW, 10=RS (set), 11=RC (clear)
req_use_imm  in  1  source is zero-extended req_imm instead of req_rs1_data
req_imm  in  5  immediate (uimm)
req_rs1_idx  in  5  rs1 register index (write-suppression rule)
req_rs1_data  in  32  rs1 value (first active thread)
req_rd  in  5  destination register
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_wid  out  NW_BITS  warp id of response
rsp_rd  out  5  destination register
rsp_wb  out  1  writeback required (rd != 0)
rsp_data  out  32  old CSR value
rsp_illegal  out  1  write attempted to read-only CSR
csr_read_enable  out  1  read strobe to CSR store
csr_read_addr  out  CSR_ADDR_BITS  read address
csr_read_wid  out  NW_BITS  read warp id
csr_read_data  in  32  combinational read data, same cycle as strobe
csr_write_enable  out  1  write strobe, single-cycle pulse
csr_write_addr  out  CSR_ADDR_BITS  write address
csr_write_wid  out  NW_BITS  write warp id
csr_write_data  out  CSR_WIDTH  write data
busy  out  1  request in flight (state != IDLE)

Behaviour:
- FSM states: IDLE, READ, WRITE, RSP.
- Reset: state=IDLE. All outputs 0, except req_ready=1.
- Reset mid-operation aborts with no write issued; the store sees no write if reset is asserted in READ or WRITE.
- IDLE:
  - req_ready=1.
  - On valid&ready, latch all request fields; go to READ.
- READ (1 cycle):
  - Drive csr_read_enable=1, csr_read_addr, csr_read_wid from latched fields.
  - Capture csr_read_data into old_r.
  - src = use_imm ? {27'b0, imm} : rs1_data.
  - new = RW: src; RS: old|src; RC: old&~src; op 00: unchanged.
  - do_write = (op==01) | ((op==10 | op==11) & (use_imm ? imm!=0 : rs1_idx!=0)).
  - ro = (addr[11:10]==2'b11).
  - Next state: WRITE if do_write & ~ro, else RSP.
  - illegal_r = do_write & ro.
- WRITE (1 cycle):
  - csr_write_enable=1; csr_write_data = new[CSR_WIDTH-1:0]; addr and wid latched. Then go to RSP.
- RSP:
  - rsp_valid=1; rsp_data=old_r; rsp_wb=(rd!=0); rsp_illegal=illegal_r.
  - Hold all rsp fields stable until rsp_ready.
  - On rsp_ready go to IDLE. A new request is accepted at the earliest in the next cycle; no bypass.
- Latency: accept at T, read at T+1, write at T+2, rsp_valid at T+3. Without a write, rsp_valid at T+2.
- csr_read_enable and csr_write_enable are never high in the same cycle.
- csr_write_enable is never high outside WRITE.
- Read-only access (op 00, or RS/RC with zero source) never writes, including to a read-only address; rsp_illegal=0.
- Outputs csr_*_addr and csr_*_wid are 0 when their strobe is low.

Test Plan:
- Reset then idle: req_ready=1, busy=0, all strobes 0 for 10 cycles.
- CSRRW addr 0x300, wid 2, rs1_idx 5, rs1_data 0xABC, store holds 0x123 → read at T+1, write 0xABC to wid 2 at T+2, rsp_data=0x123, rsp_valid at T+3.
- CSRRS imm 0x05 on 0x300 holding 0x0A0 → write 0x0A5. Then CSRRC rs1_data 0x0A0 → write 0x005, rsp_data=0x0A5.
- CSRRS rs1_idx 0 on 0xC00 (read-only) → no write, rsp_valid at T+2, rsp_illegal=0. CSRRW on 0xC00 → no write, rsp_illegal=1.
- rsp_ready held low 5 cycles → rsp fields stable, req_ready=0, no second strobe. Release → IDLE, next request accepted.
- Reset asserted in READ → next cycle state IDLE, no csr_write_enable ever seen, rsp_valid=0.
